field_cfg_loader: RTL

//  Writes a predefined start configuration into the field memory, one row per write.

---
 rtl/defs.sv | 19 +
 rtl/cfg_rom.sv | 40 ++++
 rtl/field_cfg_loader.sv | 87 ++++++++
 3 files changed

// File: rtl/defs.sv
// Shared definitions for the field/config path: load request type, field size
// defaults and the start-pattern bitmasks used by the config ROM.
package defs;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;

  localparam int FIELD_W_DEF = 32;
  localparam int FIELD_H_DEF = 32;

  // Patterns occupy the top-left 8x3 corner; index [r] is row r, bit x is column x.
  localparam int PATTERN_H = 3;
  localparam logic [PATTERN_H-1:0][7:0] CFG_1_ROWS = {8'h07, 8'h04, 8'h02};  // glider
  localparam logic [PATTERN_H-1:0][7:0] CFG_2_ROWS = {8'h00, 8'h0E, 8'h00};  // blinker

endpackage

// File: rtl/cfg_rom.sv
// Combinational start-configuration ROM: (cfg, row) -> one field row word.
// Rows outside the pattern corner and all rows of NO_REQ read as zero.
module cfg_rom
  import defs::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int ROW_AW  = 5
) (
  input  load_cfg_req_t      cfg,
  input  logic [ROW_AW-1:0]  row,
  output logic [FIELD_W-1:0] data
);

  logic [7:0] pat;
  logic [1:0] ridx;

  always_comb begin
    pat  = 8'h00;
    ridx = 2'(row);
    if (32'(row) < 32'(PATTERN_H)) begin
      case (cfg)
        CFG_1:   pat = CFG_1_ROWS[ridx];
        CFG_2:   pat = CFG_2_ROWS[ridx];
        default: pat = 8'h00;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIELD_W; gi = gi + 1) begin : g_col
      if (gi < 8) begin : g_pat
        assign data[gi] = pat[gi];
      end else begin : g_zero
        assign data[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/field_cfg_loader.sv
// Streams a predefined start configuration into the field memory, one row per
// accepted write, and reports load progress back to the load-config controller.
module field_cfg_loader
  import defs::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_go,
  input  load_cfg_req_t        i_cfg_req,
  input  logic                 i_wr_ready,
  output logic                 o_wr_en,
  output logic [((FIELD_H > 1) ? $clog2(FIELD_H) : 1)-1:0] o_wr_addr,
  output logic [FIELD_W-1:0]   o_wr_data,
  output logic                 o_is_loading,
  output logic                 o_done
);

  localparam int ROW_AW = (FIELD_H > 1) ? $clog2(FIELD_H) : 1;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(FIELD_H - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t               state_reg;
  load_cfg_req_t        cfg_q;
  logic [ROW_AW-1:0]    row_q;
  logic                 wr_en_reg;
  logic                 done_reg;
  logic [FIELD_W-1:0]   rom_data;

  cfg_rom #(
    .FIELD_W (FIELD_W),
    .ROW_AW  (ROW_AW)
  ) u_cfg_rom (
    .cfg  (cfg_q),
    .row  (row_q),
    .data (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cfg_q     <= NO_REQ;
      row_q     <= '0;
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_go) begin
            cfg_q     <= i_cfg_req;
            row_q     <= '0;
            wr_en_reg <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // i_go is deliberately not looked at here: a running load is never restarted.
          if (wr_en_reg && i_wr_ready) begin
            if (row_q == LAST_ROW) begin
              wr_en_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_is_loading = (state_reg == LOAD);
  assign o_wr_en      = wr_en_reg;
  assign o_wr_addr    = row_q;
  // The write bus is driven to zero outside a load so the core sees a quiet port.
  assign o_wr_data    = o_is_loading ? rom_data : '0;
  assign o_done       = done_reg;

endmodule
